// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: tagged command FIFO in front of a single-issue ALU.
// Issues the FIFO head over a valid/ready handshake, waits for the ALU result
// pulse, and parks the tagged result on a backpressured response port.
// Only one command is in the ALU at a time, so responses come back in order.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to add a WAIT-state watchdog
// that returns an error response after TIMEOUT_CYCLES cycles.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]   cmd_a_i,
  input  logic [DATA_WIDTH-1:0]   cmd_b_i,
  input  logic [OP_WIDTH-1:0]     cmd_op_i,
  input  logic [TAG_WIDTH-1:0]    cmd_tag_i,
  output logic                    alu_valid_o,
  input  logic                    alu_ready_i,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  output logic [OP_WIDTH-1:0]     alu_op_o,
  input  logic                    alu_valid_i,
  input  logic [DATA_WIDTH-1:0]   alu_result_i,
  input  logic                    alu_overflow_i,
  input  logic                    alu_zero_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_result_o,
  output logic                    rsp_overflow_o,
  output logic                    rsp_zero_o,
  output logic [TAG_WIDTH-1:0]    rsp_tag_o,
  output logic                    rsp_error_o,
  output logic [$clog2(DEPTH):0]  fifo_count_o,
  output logic                    busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  // Elaboration-time parameter sanity: pointer wrap relies on a power-of-2 depth.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("alu_cmd_sequencer: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem_a   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_b   [DEPTH];
  logic [OP_WIDTH-1:0]   r_mem_op  [DEPTH];
  logic [TAG_WIDTH-1:0]  r_mem_tag [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  // Control / response registers
  state_t                r_state;
  logic                  r_alu_valid;
  logic [TAG_WIDTH-1:0]  r_cur_tag;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_overflow;
  logic                  r_rsp_zero;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;

  logic w_not_full;
  logic w_push;
  logic w_pop;

  // Full blocks a push even if the head pops in the same cycle.
  assign w_not_full = (r_count < CW'(DEPTH));
  assign w_push     = cmd_valid_i && w_not_full;
  // r_alu_valid is high exactly while in ISSUE, so this is the issue handshake.
  assign w_pop      = r_alu_valid && alu_ready_i;

  // FIFO: write at tail, advance head on ALU handshake, track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i]   <= '0;
        r_mem_b[i]   <= '0;
        r_mem_op[i]  <= '0;
        r_mem_tag[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_a[r_wptr]   <= cmd_a_i;
        r_mem_b[r_wptr]   <= cmd_b_i;
        r_mem_op[r_wptr]  <= cmd_op_i;
        r_mem_tag[r_wptr] <= cmd_tag_i;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd;
  logic           r_rsp_error;
`endif

  // Sequencer FSM: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE, outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_alu_valid    <= 1'b0;
      r_cur_tag      <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_tag      <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_wd           <= '0;
      r_rsp_error    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state     <= S_ISSUE;
            r_alu_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (alu_ready_i) begin
            r_alu_valid <= 1'b0;
            r_cur_tag   <= r_mem_tag[r_rptr];
            r_state     <= S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_wd        <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A result arriving in the expiry cycle takes priority over the error.
          if (alu_valid_i) begin
            r_rsp_result   <= alu_result_i;
            r_rsp_overflow <= alu_overflow_i;
            r_rsp_zero     <= alu_zero_i;
            r_rsp_tag      <= r_cur_tag;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_HOLD;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_rsp_error    <= 1'b0;
          end else if (r_wd == WDW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_result   <= '1;
            r_rsp_overflow <= 1'b1;
            r_rsp_zero     <= 1'b0;
            r_rsp_tag      <= r_cur_tag;
            r_rsp_error    <= 1'b1;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_HOLD;
          end else begin
            r_wd <= r_wd + 1'b1;
`endif
          end
        end
        S_HOLD: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_alu_valid <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  assign rsp_error_o = r_rsp_error;
`else
  assign rsp_error_o = 1'b0;
`endif

  assign cmd_ready_o    = w_not_full;
  assign alu_valid_o    = r_alu_valid;
  assign alu_a_o        = r_mem_a[r_rptr];
  assign alu_b_o        = r_mem_b[r_rptr];
  assign alu_op_o       = r_mem_op[r_rptr];
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_result_o   = r_rsp_result;
  assign rsp_overflow_o = r_rsp_overflow;
  assign rsp_zero_o     = r_rsp_zero;
  assign rsp_tag_o      = r_rsp_tag;
  assign fifo_count_o   = r_count;
  assign busy_o         = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU responder.
// Build with ALU_SEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_alu_cmd_sequencer;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, XOR = 4'd4;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        err;
  } rsp_t;

  logic        clk, rst_n;
  logic        cmd_valid_i, cmd_ready_o;
  logic [31:0] cmd_a_i, cmd_b_i;
  logic [3:0]  cmd_op_i, cmd_tag_i;
  logic        alu_valid_o, alu_ready_i;
  logic [31:0] alu_a_o, alu_b_o;
  logic [3:0]  alu_op_o;
  logic        alu_valid_i;
  logic [31:0] alu_result_i;
  logic        alu_overflow_i, alu_zero_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_overflow_o, rsp_zero_o;
  logic [3:0]  rsp_tag_o;
  logic        rsp_error_o;
  logic [2:0]  fifo_count_o;
  logic        busy_o;

  logic m_vld, s_vld, alu_auto;
  int   checks, errors;
  rsp_t q[$];

  assign alu_valid_i = m_vld | s_vld;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i), .cmd_tag_i(cmd_tag_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i),
    .alu_overflow_i(alu_overflow_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_overflow_o(rsp_overflow_o),
    .rsp_zero_o(rsp_zero_o), .rsp_tag_o(rsp_tag_o), .rsp_error_o(rsp_error_o),
    .fifo_count_o(fifo_count_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour (external to the DUT).
  function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, b,
                                    output logic [31:0] r, output logic v);
    logic [63:0] p;
    r = '0; v = 1'b0;
    case (op)
      ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      MUL: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; v = |p[63:32]; end
      DIV: begin if (b == 0) begin r = '1; v = 1'b1; end else r = a / b; end
      XOR: r = a ^ b;
      default: r = '0;
    endcase
  endfunction

  // ALU responder: handshake at edge M, result pulse sampled at edge M+2.
  always begin
    logic [31:0] r;
    logic        v;
    @(posedge clk);
    if (alu_auto && rst_n && alu_valid_o && alu_ready_i) begin
      alu_model(alu_op_o, alu_a_o, alu_b_o, r, v);
      @(posedge clk); #1;
      alu_result_i = r; alu_overflow_i = v; alu_zero_i = (r == 0); m_vld = 1'b1;
      @(posedge clk); #1;
      m_vld = 1'b0;
    end
  end

  // Response monitor: log every accepted response.
  always @(posedge clk)
    if (rst_n && rsp_valid_o && rsp_ready_i)
      q.push_back({rsp_tag_o, rsp_result_o, rsp_overflow_o, rsp_zero_o, rsp_error_o});

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [3:0] t, input logic [31:0] r,
                              input logic o, input logic z, input logic e);
    return {t, r, o, z, e};
  endfunction

  task automatic push(input logic [31:0] a, b, input logic [3:0] op, tag);
    int g; logic ok;
    cmd_a_i = a; cmd_b_i = b; cmd_op_i = op; cmd_tag_i = tag; cmd_valid_i = 1'b1;
    g = 0;
    do begin ok = cmd_ready_o; step(); g++; end while (!ok && g < 100);
    cmd_valid_i = 1'b0;
    if (!ok) chk("push_timeout", ok, 1);
  endtask

  task automatic expect_rsp(input string nm, input rsp_t exp);
    int g; rsp_t got;
    g = 0;
    while (q.size() == 0 && g < 200) begin step(); g++; end
    chk({nm, "_arrive"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      got = q.pop_front();
      chk(nm, got, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while ((busy_o || rsp_valid_o) && g < 300) begin step(); g++; end
    chk(nm, busy_o, 0);
  endtask

  initial begin
    int g; logic ok;
    checks = 0; errors = 0;
    rst_n = 1'b0; cmd_valid_i = 0; cmd_a_i = 0; cmd_b_i = 0; cmd_op_i = 0; cmd_tag_i = 0;
    alu_ready_i = 0; alu_result_i = 0; alu_overflow_i = 0; alu_zero_i = 0;
    m_vld = 0; s_vld = 0; alu_auto = 1; rsp_ready_i = 0;
    repeat (3) step();

    // Reset state
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_alu_valid", alu_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_fields", {rsp_result_o, rsp_overflow_o, rsp_zero_o, rsp_tag_o, rsp_error_o}, 0);
    rst_n = 1'b1;
    step();

    // Single ADD: latency and one-cycle response
    alu_ready_i = 1; rsp_ready_i = 1;
    push(32'd5, 32'd3, ADD, 4'd2);
    chk("t1_count_after_push", fifo_count_o, 1);
    chk("t1_not_issued_yet", alu_valid_o, 0);
    step();
    chk("t1_issue", {alu_valid_o, alu_a_o, alu_b_o, alu_op_o}, {1'b1, 32'd5, 32'd3, ADD});
    step();
    chk("t1_popped", {alu_valid_o, fifo_count_o}, {1'b0, 3'd0});
    step();
    chk("t1_wait_no_rsp", rsp_valid_o, 0);
    step();
    chk("t1_rsp", {rsp_valid_o, rsp_result_o, rsp_overflow_o, rsp_zero_o, rsp_tag_o, rsp_error_o},
        {1'b1, 32'd8, 1'b0, 1'b0, 4'd2, 1'b0});
    step();
    chk("t1_rsp_one_cycle", rsp_valid_o, 0);
    chk("t1_logged", q.size(), 1);
    q.delete();
    wait_idle("t1_idle");

    // Back-to-back ops, responses in tag order
    push(32'd7, 32'd6, MUL, 4'd0);
    push(32'd4, 32'd4, SUB, 4'd1);
    push(32'd9, 32'd0, DIV, 4'd2);
    push(32'hF0F0_0000, 32'hFFFF_FFFF, XOR, 4'd3);
    expect_rsp("t2_mul", mk(4'd0, 32'd42, 0, 0, 0));
    expect_rsp("t2_sub", mk(4'd1, 32'd0, 0, 1, 0));
    expect_rsp("t2_div", mk(4'd2, 32'hFFFF_FFFF, 1, 0, 0));
    expect_rsp("t2_xor", mk(4'd3, 32'h0F0F_FFFF, 0, 0, 0));
    wait_idle("t2_idle");

    // ALU stalls 10 cycles in ISSUE: head held stable, no pop
    alu_ready_i = 0;
    push(32'h1234, 32'h10, SUB, 4'd5);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t6_stall_hold", {alu_valid_o, alu_a_o, alu_b_o, alu_op_o, fifo_count_o},
          {1'b1, 32'h1234, 32'h10, SUB, 3'd1});
      step();
    end
    alu_ready_i = 1;
    step();
    chk("t6_released", {alu_valid_o, fifo_count_o}, {1'b0, 3'd0});
    expect_rsp("t6_rsp", mk(4'd5, 32'h1224, 0, 0, 0));
    wait_idle("t6_idle");

    // Response backpressure: first parks in HOLD, FIFO fills, 6th stalls
    rsp_ready_i = 0;
    for (int i = 0; i < 5; i++) push(32'd100 + i, i, ADD, 4'(8 + i));
    cmd_a_i = 32'd105; cmd_b_i = 32'd5; cmd_op_i = ADD; cmd_tag_i = 4'd13; cmd_valid_i = 1;
    repeat (4) step();
    chk("t3_full", {cmd_ready_o, fifo_count_o}, {1'b0, 3'd4});
    chk("t3_parked", {rsp_valid_o, rsp_tag_o, rsp_result_o}, {1'b1, 4'd8, 32'd100});
    chk("t3_none_out", q.size(), 0);
    rsp_ready_i = 1;
    g = 0;
    do begin ok = cmd_ready_o; step(); g++; end while (!ok && g < 100);
    cmd_valid_i = 0;
    chk("t3_sixth_accepted", ok, 1);
    for (int i = 0; i < 6; i++)
      expect_rsp("t3_rsp", mk(4'(8 + i), 32'd100 + 32'(2 * i), 0, 0, 0));
    wait_idle("t3_idle");

`ifdef ALU_SEQ_TIMEOUT_EN
    // Watchdog: no ALU result -> error response after 16 WAIT cycles
    alu_auto = 0; rsp_ready_i = 0;
    push(32'd1, 32'd1, ADD, 4'd6);
    g = 0;
    while (!alu_valid_o && g < 20) begin step(); g++; end
    chk("to_issue", alu_valid_o, 1);
    step();
    repeat (15) step();
    chk("to_not_yet", rsp_valid_o, 0);
    step();
    chk("to_rsp", {rsp_valid_o, rsp_error_o, rsp_result_o, rsp_overflow_o, rsp_zero_o, rsp_tag_o},
        {1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd6});
    rsp_ready_i = 1;
    expect_rsp("to_logged", mk(4'd6, 32'hFFFF_FFFF, 1, 0, 1));
    alu_auto = 1;
    wait_idle("to_idle");
    push(32'd2, 32'd2, ADD, 4'd7);
    expect_rsp("to_next_ok", mk(4'd7, 32'd4, 0, 0, 0));
    wait_idle("to_idle2");
`endif

    // Reset during WAIT with 3 commands queued; stray result afterwards
    alu_auto = 0; q.delete();
    for (int i = 0; i < 4; i++) push(32'd20 + i, 32'd1, ADD, 4'(i));
    chk("rs_queued", {fifo_count_o, alu_valid_o, busy_o}, {3'd3, 1'b0, 1'b1});
    repeat (5) step();
`ifndef ALU_SEQ_TIMEOUT_EN
    repeat (25) step();
    chk("rs_wait_forever", {rsp_valid_o, rsp_error_o}, 0);
`endif
    rst_n = 1'b0;
    step();
    chk("rs_outputs", {cmd_ready_o, fifo_count_o, busy_o, alu_valid_o, rsp_valid_o},
        {1'b1, 3'd0, 1'b0, 1'b0, 1'b0});
    chk("rs_rsp_fields", {rsp_result_o, rsp_overflow_o, rsp_zero_o, rsp_tag_o, rsp_error_o}, 0);
    rst_n = 1'b1;
    step();
    s_vld = 1; alu_result_i = 32'hDEAD; step(); s_vld = 0;
    repeat (4) step();
    chk("rs_stray_ignored", {rsp_valid_o, busy_o, fifo_count_o}, 0);
    chk("rs_no_rsp_logged", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the ALU stage: buffers tagged ALU commands in a DEPTH-entry FIFO and issues them one at a time over the ALU valid/ready input handshake. It waits for the ALU's single-cycle result pulse, captures result/overflow/zero with the command's tag, and presents them on a backpressured response port. At most one command is in flight in the ALU, so responses return strictly in command order.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, opcode width (ALU encoding, passed through unmodified)
- TAG_WIDTH, 4, command tag width
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT_CYCLES, 16, watchdog limit in WAIT (used only with ALU_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  FIFO not full
- cmd_a_i / cmd_b_i  in  DATA_WIDTH  operands
- cmd_op_i  in  OP_WIDTH  opcode
- cmd_tag_i  in  TAG_WIDTH  tag returned with response
- alu_valid_o  out  1  command presented to ALU
- alu_ready_i  in  1  ALU ready
- alu_a_o / alu_b_o  out  DATA_WIDTH  head-entry operands
- alu_op_o  out  OP_WIDTH  head-entry opcode
- alu_valid_i  in  1  ALU result pulse
- alu_result_i  in  DATA_WIDTH  ALU result
- alu_overflow_i / alu_zero_i  in  1  ALU flags
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_result_o  out  DATA_WIDTH  captured result
- rsp_overflow_o / rsp_zero_o  out  1  captured flags
- rsp_tag_o  out  TAG_WIDTH  tag of completed command
- rsp_error_o  out  1  watchdog expiry
- fifo_count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- busy_o  out  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: push on cmd_valid_i && cmd_ready_o; cmd_ready_o = (count < DEPTH). When full, no push even if a pop occurs the same cycle. Pop in ISSUE on alu_ready_i. Simultaneous push/pop when not full: count unchanged. Pointers wrap modulo DEPTH.
- alu_a_o/alu_b_o/alu_op_o always show the FIFO head (don't-care when empty).
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: count != 0 -> ISSUE. alu_valid_i ignored.
  - ISSUE: alu_valid_o=1. On alu_ready_i: pop, latch head tag, clear watchdog -> WAIT.
  - WAIT: on alu_valid_i capture result, flags, tag, rsp_error_o=0 -> HOLD. Watchdog expiry -> see Configuration.
  - HOLD: rsp_valid_o=1, response fields stable. On rsp_ready_i -> IDLE. alu_valid_i ignored.
- Response fields hold their last value outside HOLD.

## Timing
- Reset: state IDLE, FIFO empty, all outputs 0 (cmd_ready_o=1, fifo_count_o=0, busy_o=0). Reset mid-operation discards FIFO contents and the in-flight command. A late alu_valid_i after reset is ignored.
- Command accepted at edge N -> count=1 after N -> ISSUE after N+1 (alu_valid_o high in cycle N+2).
- ALU handshake at edge M -> WAIT. Single-cycle ops: alu_valid_i high during cycle M+2 -> HOLD after edge M+2.
- rsp_ready_i at edge K -> IDLE -> next ISSUE no earlier than after K+1. Minimum throughput: one command per 5 cycles.
- alu_valid_o never drops without alu_ready_i.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined: WAIT counts cycles. If alu_valid_i is not seen by the TIMEOUT_CYCLES-th cycle in WAIT, go to HOLD with rsp_error_o=1, rsp_result_o all ones, rsp_overflow_o=1, rsp_zero_o=0, and the latched tag. If alu_valid_i arrives in the expiry cycle, the result wins.
- Undefined: no counter. WAIT lasts indefinitely and rsp_error_o is tied 0.

## Test plan
- ADD a=5 b=3 tag=2, rsp_ready_i=1 -> rsp_result_o=8, rsp_overflow_o=0, rsp_zero_o=0, rsp_tag_o=2, rsp_valid_o high exactly 1 cycle.
- Tags 0..3 with ops MUL 7*6, SUB 4-4, DIV 9/0, XOR F0F0_0000^FFFF_FFFF, pushed back to back -> responses in tag order: 42; 0 with zero=1; FFFFFFFF with overflow=1; 0F0F_FFFF.
- rsp_ready_i=0, push 6 commands -> first command parks in HOLD, FIFO fills to 4, fifo_count_o=4, cmd_ready_o=0, 6th command stalls. Release rsp_ready_i -> all 6 responses return in order.
- With ALU_SEQ_TIMEOUT_EN, bench ALU never pulses alu_valid_i -> after 16 WAIT cycles: rsp_error_o=1, rsp_result_o=FFFFFFFF, correct tag. Next command proceeds normally.
- Assert rst_n low during WAIT with 3 commands queued -> outputs reset, fifo_count_o=0, cmd_ready_o=1. A stray alu_valid_i one cycle after reset produces no response.
- alu_ready_i held low 10 cycles during ISSUE -> alu_valid_o and alu_a_o/alu_b_o/alu_op_o held stable, no pop, until alu_ready_i rises.
